// File: rtl/lcd_pkg.sv
// Shared definitions for the RGB LCD timing generator: supported panel IDs,
// the per-panel timing set and the controller state encoding.
package lcd_pkg;

  localparam int LCD_CNT_W = 11;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_4384 = 16'h4384;
  localparam logic [15:0] ID_1018 = 16'h1018;

  typedef struct packed {
    logic [LCD_CNT_W-1:0] h_sync;
    logic [LCD_CNT_W-1:0] h_back;
    logic [LCD_CNT_W-1:0] h_disp;
    logic [LCD_CNT_W-1:0] h_total;
    logic [LCD_CNT_W-1:0] v_sync;
    logic [LCD_CNT_W-1:0] v_back;
    logic [LCD_CNT_W-1:0] v_disp;
    logic [LCD_CNT_W-1:0] v_total;
  } lcd_timing_t;

  localparam lcd_timing_t TIMING_NONE = '0;

  localparam lcd_timing_t TIMING_4342 = '{
    h_sync: 11'd41,  h_back: 11'd2,   h_disp: 11'd480,  h_total: 11'd525,
    v_sync: 11'd10,  v_back: 11'd2,   v_disp: 11'd272,  v_total: 11'd286};
  localparam lcd_timing_t TIMING_7084 = '{
    h_sync: 11'd128, h_back: 11'd88,  h_disp: 11'd800,  h_total: 11'd1056,
    v_sync: 11'd2,   v_back: 11'd33,  v_disp: 11'd480,  v_total: 11'd525};
  localparam lcd_timing_t TIMING_7016 = '{
    h_sync: 11'd20,  h_back: 11'd140, h_disp: 11'd1024, h_total: 11'd1344,
    v_sync: 11'd3,   v_back: 11'd20,  v_disp: 11'd600,  v_total: 11'd635};
  localparam lcd_timing_t TIMING_4384 = '{
    h_sync: 11'd48,  h_back: 11'd88,  h_disp: 11'd800,  h_total: 11'd976,
    v_sync: 11'd3,   v_back: 11'd32,  v_disp: 11'd480,  v_total: 11'd528};
  localparam lcd_timing_t TIMING_1018 = '{
    h_sync: 11'd10,  h_back: 11'd80,  h_disp: 11'd1280, h_total: 11'd1440,
    v_sync: 11'd3,   v_back: 11'd10,  v_disp: 11'd800,  v_total: 11'd823};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } lcd_state_e;

endpackage

// File: rtl/lcd_timing_gen_if.sv
// LCD-side bundle: ID reader inputs, pixel-source handshake and the RGB bus.
interface lcd_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic [15:0]      lcd_id;
  logic             id_valid;
  logic [23:0]      pixel_data;
  logic             data_req;
  logic [CNT_W-1:0] pixel_xpos;
  logic [CNT_W-1:0] pixel_ypos;
  logic             lcd_hs;
  logic             lcd_vs;
  logic             lcd_de;
  logic [23:0]      lcd_rgb_o;
  logic             lcd_rgb_oe;
  logic             lcd_bl;
  logic             id_err;

  modport master (
    input  lcd_id, id_valid, pixel_data,
    output data_req, pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de,
           lcd_rgb_o, lcd_rgb_oe, lcd_bl, id_err
  );

  modport slave (
    output lcd_id, id_valid, pixel_data,
    input  data_req, pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de,
           lcd_rgb_o, lcd_rgb_oe, lcd_bl, id_err
  );
endinterface

// File: rtl/lcd_timing_rom.sv
// Maps a panel ID to its timing set; unknown IDs (including 0) report unsupported.
module lcd_timing_rom
  import lcd_pkg::*;
(
  input  logic [15:0] lcd_id,
  output lcd_timing_t timing,
  output logic        supported
);

  // ID decode
  always_comb begin
    timing    = TIMING_NONE;
    supported = 1'b0;
    case (lcd_id)
      ID_4342: begin timing = TIMING_4342; supported = 1'b1; end
      ID_7084: begin timing = TIMING_7084; supported = 1'b1; end
      ID_7016: begin timing = TIMING_7016; supported = 1'b1; end
      ID_4384: begin timing = TIMING_4384; supported = 1'b1; end
      ID_1018: begin timing = TIMING_1018; supported = 1'b1; end
      default: begin timing = TIMING_NONE; supported = 1'b0; end
    endcase
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB LCD timing generator: latches the panel timing once after reset, then
// free-runs HS/VS/DE, pixel coordinates and the request, and registers pixel data.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int CNT_W = LCD_CNT_W
) (
  input logic              clk,
  input logic              rst,
  lcd_timing_gen_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  lcd_state_e       state_r, state_s;
  lcd_timing_t      timing_r, timing_s, rom_timing_s;
  logic             rom_ok_s;
  logic [CNT_W-1:0] h_cnt_r, v_cnt_r, h_next_s, v_next_s;
  logic [CNT_W-1:0] h_sync_s, h_act_s, h_end_s, h_req_s;
  logic [CNT_W-1:0] v_sync_s, v_act_s, v_end_s;
  logic             run_s, v_win_s, hs_s, vs_s, de_s, req_s, oe_s, err_s;
  logic [CNT_W-1:0] xpos_s, ypos_s;
  logic             req_r, hs_r, vs_r, de_r, oe_r, err_r;
  logic [CNT_W-1:0] xpos_r, ypos_r;
  logic [23:0]      rgb_r;

  lcd_timing_rom u_rom (
    .lcd_id    (bus.lcd_id),
    .timing    (rom_timing_s),
    .supported (rom_ok_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // FSM next state; RUN and ERR are only left through reset
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (bus.id_valid) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD: if (rom_ok_s)     state_s = ST_RUN;  else state_s = ST_ERR;
      ST_RUN:  state_s = ST_RUN;
      ST_ERR:  state_s = ST_ERR;
      default: state_s = ST_IDLE;
    endcase
  end

  // Timing latch source and next counter values
  always_comb begin
    timing_s = timing_r;
    h_next_s = '0;
    v_next_s = '0;
    if (state_r == ST_LOAD) timing_s = rom_timing_s;
    else                    timing_s = timing_r;
    if (state_r == ST_RUN) begin
      if (h_cnt_r == CNT_W'(timing_r.h_total) - CNT_ONE) begin
        h_next_s = '0;
        if (v_cnt_r == CNT_W'(timing_r.v_total) - CNT_ONE) v_next_s = '0;
        else                                                v_next_s = v_cnt_r + CNT_ONE;
      end else begin
        h_next_s = h_cnt_r + CNT_ONE;
        v_next_s = v_cnt_r;
      end
    end else begin
      h_next_s = '0;
      v_next_s = '0;
    end
  end

  // Timing set and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      timing_r <= TIMING_NONE;
      h_cnt_r  <= '0;
      v_cnt_r  <= '0;
    end else begin
      timing_r <= timing_s;
      h_cnt_r  <= h_next_s;
      v_cnt_r  <= v_next_s;
    end
  end

  // Output decode from the counter values that will be live next cycle,
  // so each registered output lines up with the counter it describes
  always_comb begin
    run_s    = (state_s == ST_RUN);
    h_sync_s = CNT_W'(timing_s.h_sync);
    h_act_s  = h_sync_s + CNT_W'(timing_s.h_back);
    h_end_s  = h_act_s + CNT_W'(timing_s.h_disp);
    v_sync_s = CNT_W'(timing_s.v_sync);
    v_act_s  = v_sync_s + CNT_W'(timing_s.v_back);
    v_end_s  = v_act_s + CNT_W'(timing_s.v_disp);
    h_req_s  = h_next_s + CNT_ONE;
    v_win_s  = (v_next_s >= v_act_s) && (v_next_s < v_end_s);
    hs_s     = ~(run_s && (h_next_s < h_sync_s));
    vs_s     = ~(run_s && (v_next_s < v_sync_s));
    de_s     = run_s && v_win_s && (h_next_s >= h_act_s) && (h_next_s < h_end_s);
    // request window is the DE window shifted one column earlier
    req_s    = run_s && v_win_s && (h_req_s >= h_act_s) && (h_req_s < h_end_s);
    oe_s     = run_s;
    err_s    = (state_s == ST_ERR);
    if (req_s) begin
      xpos_s = h_req_s - h_act_s;
      ypos_s = v_next_s - v_act_s;
    end else begin
      xpos_s = '0;
      ypos_s = '0;
    end
  end

  // Output registers; pixel data is captured the cycle after its request
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r  <= 1'b0;
      xpos_r <= '0;
      ypos_r <= '0;
      hs_r   <= 1'b1;
      vs_r   <= 1'b1;
      de_r   <= 1'b0;
      oe_r   <= 1'b0;
      err_r  <= 1'b0;
      rgb_r  <= 24'h000000;
    end else begin
      req_r  <= req_s;
      xpos_r <= xpos_s;
      ypos_r <= ypos_s;
      hs_r   <= hs_s;
      vs_r   <= vs_s;
      de_r   <= de_s;
      oe_r   <= oe_s;
      err_r  <= err_s;
      rgb_r  <= req_r ? bus.pixel_data : 24'h000000;
    end
  end

  assign bus.data_req   = req_r;
  assign bus.pixel_xpos = xpos_r;
  assign bus.pixel_ypos = ypos_r;
  assign bus.lcd_hs     = hs_r;
  assign bus.lcd_vs     = vs_r;
  assign bus.lcd_de     = de_r;
  assign bus.lcd_rgb_o  = rgb_r;
  assign bus.lcd_rgb_oe = oe_r;
  assign bus.lcd_bl     = oe_r;
  assign bus.id_err     = err_r;

endmodule
